pl_stage_6: RTL and testbench



---
 rtl/pl_stage_6_pkg.sv | 32 +++
 rtl/pl_stage_6_flipabs.sv | 26 ++
 rtl/pl_stage_6.sv | 176 +++++++++++++++++
 tb/tb_pl_stage_6.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pl_stage_6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pl_stage_6_pkg
// Description : Shared constants and types for the NewHope decode stage:
//               modulus, decode centre, polynomial length, bus widths and
//               the stage FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pl_stage_6_pkg;

  localparam int unsigned Q       = 12289;
  localparam int unsigned HALF_Q  = 6144;
  localparam int unsigned N       = 512;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned COEFF_W = 14;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MSG_AW  = 5;

  // Sized copies so datapath arithmetic stays width-matched.
  localparam logic [COEFF_W-1:0] Q_COEFF      = COEFF_W'(Q);
  localparam logic [COEFF_W-1:0] HALF_Q_COEFF = COEFF_W'(HALF_Q);
  localparam logic [ADDR_W-1:0]  K_LAST       = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pl_stage_6_flipabs.sv
`default_nettype none
// ============================================================================
// Module      : newhope_flipabs
// Description : Distance of a reduced coefficient from the decode centre,
//               y = |x - HALF_Q|. Input must be < Q, so y is in [0, HALF_Q].
// Ports       : x - reduced coefficient (COEFF_W bits)
//               y - |x - HALF_Q| (COEFF_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module newhope_flipabs
  import pl_stage_6_pkg::*;
(
  input  logic [COEFF_W-1:0] x,
  output logic [COEFF_W-1:0] y
);

  always_comb begin
    if (x < HALF_Q_COEFF) begin
      y = HALF_Q_COEFF - x;
    end else begin
      y = x - HALF_Q_COEFF;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pl_stage_6.sv
`default_nettype none
// ============================================================================
// Module      : pl_stage_6
// Description : Decryption decode stage. Streams r1 and v (512 coeffs mod Q)
//               out of two synchronous RAMs, forms d = (v - r1) mod Q,
//               NewHope-decodes pairs (j, j+256) into message bits and writes
//               the 256-bit message LSB-first as 32 bytes.
// Ports       : clk, rst (async, active-low), en (global clock enable)
//               start_stage / done_stage   - stage handshake pulses
//               addr_r1/dout_r1, addr_v/dout_v - RAM read ports (1-cycle)
//               we_msg/addr_msg/dout_msg   - message RAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module pl_stage_6
  import pl_stage_6_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start_stage,
  output logic              done_stage,
  output logic [ADDR_W-1:0] addr_r1,
  input  logic [DATA_W-1:0] dout_r1,
  output logic [ADDR_W-1:0] addr_v,
  input  logic [DATA_W-1:0] dout_v,
  output logic              we_msg,
  output logic [MSG_AW-1:0] addr_msg,
  output logic [7:0]        dout_msg
);

  // Control state
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [1:0]          flush_q, flush_d;
  logic                done_q, done_d;

  // Read-return tracking: vld_q marks that dout_* carries data for index kp_q
  logic                vld_q, vld_d;
  logic [ADDR_W-1:0]   kp_q, kp_d;

  // Decode / packing state
  logic [COEFF_W-1:0]  lo_abs_q, lo_abs_d;
  logic [7:0]          byte_q, byte_d;
  logic                we_q, we_d;
  logic [MSG_AW-1:0]   addr_msg_q, addr_msg_d;
  logic [7:0]          dout_msg_q, dout_msg_d;

  // Datapath wires
  logic [COEFF_W:0]    diff;
  logic [COEFF_W-1:0]  d_mod;
  logic [COEFF_W-1:0]  a_abs;
  logic [COEFF_W:0]    t_sum;
  logic                bit_j;
  logic                unused_hi_bits;

  // Upper RAM bits carry no information for coefficients < Q.
  assign unused_hi_bits = ^{dout_r1[DATA_W-1:COEFF_W], dout_v[DATA_W-1:COEFF_W]};

  // Even k fetches coefficient j, odd k its partner j+256.
  assign addr_r1    = {k_q[0], k_q[ADDR_W-1:1]};
  assign addr_v     = addr_r1;
  assign done_stage = done_q;
  assign we_msg     = we_q;
  assign addr_msg   = addr_msg_q;
  assign dout_msg   = dout_msg_q;

  // Modular subtract: a borrow out of the 15-bit difference means v < r1,
  // and adding Q in 14-bit arithmetic lands back in [0, Q-1].
  always_comb begin
    diff  = {1'b0, dout_v[COEFF_W-1:0]} - {1'b0, dout_r1[COEFF_W-1:0]};
    d_mod = diff[COEFF_W] ? (diff[COEFF_W-1:0] + Q_COEFF) : diff[COEFF_W-1:0];
  end

  newhope_flipabs u_flipabs (
    .x (d_mod),
    .y (a_abs)
  );

  always_comb begin
    t_sum = {1'b0, lo_abs_q} + {1'b0, a_abs};
    bit_j = (t_sum < {1'b0, HALF_Q_COEFF});
  end

  // FSM: next state, counter and read-return tracking
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    flush_d = flush_q;
    vld_d   = 1'b0;
    kp_d    = kp_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_stage) begin
          state_d = ST_RUN;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        vld_d = 1'b1;
        kp_d  = k_q;
        k_d   = k_q + ADDR_W'(1);
        if (k_q == K_LAST) begin
          state_d = ST_FLUSH;
          flush_d = 2'd0;
        end
      end
      ST_FLUSH: begin
        // Step 0 retires the last pair, step 1 raises done, step 2 returns
        // to IDLE so a start coinciding with done is not sampled.
        flush_d = flush_q + 2'd1;
        if (flush_q == 2'd1) begin
          done_d = 1'b1;
        end
        if (flush_q == 2'd2) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode and byte packing on returned read data
  always_comb begin
    lo_abs_d   = lo_abs_q;
    byte_d     = byte_q;
    we_d       = 1'b0;
    addr_msg_d = addr_msg_q;
    dout_msg_d = dout_msg_q;
    if (vld_q) begin
      if (!kp_q[0]) begin
        lo_abs_d = a_abs;
      end else begin
        // Shift in at the MSB: after eight bits the first one sits at bit 0.
        byte_d = {bit_j, byte_q[7:1]};
        if (kp_q[3:1] == 3'b111) begin
          we_d       = 1'b1;
          addr_msg_d = kp_q[ADDR_W-1:4];
          dout_msg_d = {bit_j, byte_q[7:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      flush_q    <= '0;
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
      kp_q       <= '0;
      lo_abs_q   <= '0;
      byte_q     <= '0;
      we_q       <= 1'b0;
      addr_msg_q <= '0;
      dout_msg_q <= '0;
    end else if (en) begin
      state_q    <= state_d;
      k_q        <= k_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
      kp_q       <= kp_d;
      lo_abs_q   <= lo_abs_d;
      byte_q     <= byte_d;
      we_q       <= we_d;
      addr_msg_q <= addr_msg_d;
      dout_msg_q <= dout_msg_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pl_stage_6.sv
`default_nettype none
// ============================================================================
// Module      : tb_pl_stage_6
// Description : Self-checking bench for pl_stage_6. A reference decoder
//               fills a queue of expected message bytes per run; a monitor
//               pops and compares each message write, its active-cycle
//               position and the done pulse timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pl_stage_6;

  localparam int M_Q    = 12289;
  localparam int M_HALF = 6144;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        start_stage = 1'b0;
  logic        done_stage;
  logic [8:0]  addr_r1;
  logic [15:0] dout_r1 = '0;
  logic [8:0]  addr_v;
  logic [15:0] dout_v = '0;
  logic        we_msg;
  logic [4:0]  addr_msg;
  logic [7:0]  dout_msg;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  int   r1_mem [512];
  int   v_mem  [512];
  exp_t exp_q  [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   act_cnt = 0;   // index of the next enabled clock edge since start
  bit   done_seen = 1'b0;

  pl_stage_6 dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start_stage (start_stage),
    .done_stage  (done_stage),
    .addr_r1     (addr_r1),
    .dout_r1     (dout_r1),
    .addr_v      (addr_v),
    .dout_v      (dout_v),
    .we_msg      (we_msg),
    .addr_msg    (addr_msg),
    .dout_msg    (dout_msg)
  );

  always #5 clk = ~clk;

  // Source RAMs: synchronous read, enable tied to en.
  always @(posedge clk) begin
    if (en) begin
      dout_r1 <= 16'(r1_mem[addr_r1]);
      dout_v  <= 16'(v_mem[addr_v]);
    end
  end

  always @(posedge clk) begin
    if (en) act_cnt = act_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: NewHope decode of each pair, bytes packed LSB-first.
  function automatic int fold(input int x);
    return (x > M_HALF) ? (x - M_HALF) : (M_HALF - x);
  endfunction

  task automatic build_expected();
    exp_q.delete();
    for (int b = 0; b < 32; b++) begin
      int byte_v;
      byte_v = 0;
      for (int i = 0; i < 8; i++) begin
        int j, d0, d1;
        j  = 8 * b + i;
        d0 = ((v_mem[j] - r1_mem[j]) % M_Q + M_Q) % M_Q;
        d1 = ((v_mem[j + 256] - r1_mem[j + 256]) % M_Q + M_Q) % M_Q;
        if (fold(d0) + fold(d1) < M_HALF) byte_v = byte_v | (1 << i);
      end
      exp_q.push_back('{addr: b, data: byte_v});
    end
  endtask

  function automatic int rnd_coeff();
    int corners [4];
    corners = '{0, 6144, 6145, 12288};
    if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
    return int'($urandom_range(M_Q - 1));
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0: begin r1_mem[i] = 0; v_mem[i] = 0; end
        1: begin r1_mem[i] = 0; v_mem[i] = M_HALF; end
        2: begin r1_mem[i] = 0; v_mem[i] = (i == 0 || i == 256) ? M_HALF : 0; end
        3: begin
          if ((i % 256) < 128) begin r1_mem[i] = 6145; v_mem[i] = 0; end
          else begin r1_mem[i] = 0; v_mem[i] = 12288; end
        end
        default: begin r1_mem[i] = rnd_coeff(); v_mem[i] = rnd_coeff(); end
      endcase
    end
  endtask

  // Monitor: every write/done the message RAM would actually accept.
  always @(negedge clk) begin
    if (rst && en) begin
      if (we_msg) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr %0d data %0d with nothing expected", addr_msg, dout_msg);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("msg_addr", 32'(addr_msg), e.addr);
          check("msg_byte", 32'(dout_msg), e.data);
          check("write_cycle", act_cnt, 16 * e.addr + 18);
        end
      end
      if (done_stage) begin
        check("done_cycle", act_cnt, 515);
        check("writes_left_at_done", exp_q.size(), 0);
        done_seen = 1'b1;
      end
    end
  end

  // One full run. stall_pct: chance (%) of en low per cycle.
  // spurious_at: active cycle at which an extra start is pulsed (-1: none).
  task automatic run(input int stall_pct, input int spurious_at);
    int guard;
    build_expected();
    done_seen = 1'b0;
    @(posedge clk); #1;
    en = 1'b1;
    start_stage = 1'b1;
    act_cnt = 0;
    @(posedge clk); #1;
    start_stage = 1'b0;
    guard = 0;
    while (!done_seen && guard < 3000) begin
      en = ($urandom_range(99) >= stall_pct);
      start_stage = (act_cnt == spurious_at) || (act_cnt == 515);
      @(posedge clk); #1;
      guard++;
    end
    start_stage = 1'b0;
    en = 1'b1;
    n_cmp++;
    if (!done_seen) begin
      n_bad++;
      $display("FAIL done_timeout: no done_stage within %0d cycles", guard);
    end
    // A start accepted alongside done would have moved the read address.
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_done_addr", 32'(addr_r1), 0);
    check("idle_after_done_flag", 32'(done_stage), 0);
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_done"},     32'(done_stage), 0);
    check({tag, "_we"},       32'(we_msg), 0);
    check({tag, "_addr_msg"}, 32'(addr_msg), 0);
    check({tag, "_dout_msg"}, 32'(dout_msg), 0);
    check({tag, "_addr_r1"},  32'(addr_r1), 0);
    check({tag, "_addr_v"},   32'(addr_v), 0);
  endtask

  initial begin
    #23;
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("idle");

    fill(0); run(0, -1);
    fill(1); run(0, -1);
    fill(2); run(0, -1);
    fill(3); run(0, -1);
    fill(4); run(0, -1);
    fill(4); run(0, 100);
    fill(4); run(30, -1);
    fill(4); run(50, 300);

    // Asynchronous reset in the middle of a run
    fill(4);
    build_expected();
    @(posedge clk); #1;
    en = 1'b1;
    start_stage = 1'b1;
    act_cnt = 0;
    @(posedge clk); #1;
    start_stage = 1'b0;
    for (int g = 0; g < 1000 && act_cnt < 200; g++) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    fill(4); run(0, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
